// File: rtl/dht_pkg.sv
// Shared types and constants for the DHT BCD formatter.
// Holds the FSM state enum, default limits and the double-dabble step.
package dht_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_CONV_HUM,
    S_CONV_TEMP,
    S_PRESENT
  } dht_state_e;

  localparam int HUM_MAX_DEF  = 1000;
  localparam int TEMP_MAX_DEF = 800;
  localparam int CONV_LEN     = 16;
  localparam int NUM_DIGITS   = 4;

  // One double-dabble step on {bcd[15:0], bin[15:0]}: add-3 then shift.
  function automatic logic [31:0] dd_step(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (y[16+4*d +: 4] >= 4'd5)
        y[16+4*d +: 4] = y[16+4*d +: 4] + 4'd3;
    end
    return {y[30:0], 1'b0};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 4-digit BCD converter, one shift per clock.
// The start cycle performs the first shift, so a result takes 16 clocks.
module bin2bcd_seq
  import dht_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [15:0] i_bin,
  output logic        o_done,
  output logic [15:0] o_bcd
);

  logic [31:0] r_sr;
  logic [3:0]  r_cnt;
  logic        r_run;
  logic [31:0] w_next;

  assign w_next = dd_step(r_sr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_sr  <= dd_step({16'h0000, i_bin});
      r_cnt <= 4'd1;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_sr  <= w_next;
      r_cnt <= r_cnt + 4'd1;
      if (r_cnt == 4'(CONV_LEN - 1))
        r_run <= 1'b0;
    end
  end

  // Done marks the cycle whose edge applies the final shift.
  assign o_done = r_run && (r_cnt == 4'(CONV_LEN - 1));
  assign o_bcd  = w_next[31:16];

endmodule

// File: rtl/dht_bcd_formatter.sv
// DHT sensor word to BCD formatter with valid/ready result handshake.
// Define DHT_FMT_RANGE_CHECK_EN to reject out-of-range samples instead of clamping.
module dht_bcd_formatter
  import dht_pkg::*;
#(
  parameter int HUM_MAX  = HUM_MAX_DEF,
  parameter int TEMP_MAX = TEMP_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dht_data,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] hum_bcd,
  output logic [15:0] temp_bcd,
  output logic        temp_neg,
  output logic        range_err,
  output logic        busy
);

  dht_state_e  r_state;
  logic [31:0] r_last;
  logic [15:0] r_hum_w;
  logic [15:0] r_temp_w;
  logic        r_neg_w;
  logic [15:0] r_hum_res;
  logic        r_start;
  logic        r_valid;
  logic [15:0] r_hum_bcd;
  logic [15:0] r_temp_bcd;
  logic        r_temp_neg;
`ifdef DHT_FMT_RANGE_CHECK_EN
  logic        r_range_err;
`endif

  logic [15:0] w_hum_raw;
  logic [15:0] w_tmag;
  logic        w_hum_oor;
  logic        w_temp_oor;
  logic [15:0] w_conv_in;
  logic        w_done;
  logic [15:0] w_bcd;

  assign w_hum_raw  = dht_data[31:16];
  assign w_tmag     = {1'b0, dht_data[14:0]};
  assign w_hum_oor  = w_hum_raw > 16'(HUM_MAX);
  assign w_temp_oor = w_tmag > 16'(TEMP_MAX);
  assign w_conv_in  = (r_state == S_CONV_TEMP) ? r_temp_w : r_hum_w;

  bin2bcd_seq u_conv (
    .clk     (clk),
    .rst     (rst),
    .i_start (r_start),
    .i_bin   (w_conv_in),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_last     <= '0;
      r_hum_w    <= '0;
      r_temp_w   <= '0;
      r_neg_w    <= 1'b0;
      r_hum_res  <= '0;
      r_start    <= 1'b0;
      r_valid    <= 1'b0;
      r_hum_bcd  <= '0;
      r_temp_bcd <= '0;
      r_temp_neg <= 1'b0;
`ifdef DHT_FMT_RANGE_CHECK_EN
      r_range_err <= 1'b0;
`endif
    end else begin
      r_start <= 1'b0;
`ifdef DHT_FMT_RANGE_CHECK_EN
      r_range_err <= 1'b0;
`endif
      unique case (r_state)
        S_IDLE: begin
          if (dht_data != r_last)
            r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_last   <= dht_data;
          r_hum_w  <= w_hum_oor ? 16'(HUM_MAX) : w_hum_raw;
          r_temp_w <= w_temp_oor ? 16'(TEMP_MAX) : w_tmag;
          r_neg_w  <= dht_data[15] && (w_tmag != 16'h0000);
`ifdef DHT_FMT_RANGE_CHECK_EN
          if (w_hum_oor || w_temp_oor) begin
            r_range_err <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_start <= 1'b1;
            r_state <= S_CONV_HUM;
          end
`else
          r_start <= 1'b1;
          r_state <= S_CONV_HUM;
`endif
        end
        S_CONV_HUM: begin
          if (w_done) begin
            r_hum_res <= w_bcd;
            r_start   <= 1'b1;
            r_state   <= S_CONV_TEMP;
          end
        end
        S_CONV_TEMP: begin
          if (w_done) begin
            r_hum_bcd  <= r_hum_res;
            r_temp_bcd <= w_bcd;
            r_temp_neg <= r_neg_w;
            r_valid    <= 1'b1;
            r_state    <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = r_valid;
  assign hum_bcd   = r_hum_bcd;
  assign temp_bcd  = r_temp_bcd;
  assign temp_neg  = r_temp_neg;
  assign busy      = (r_state != S_IDLE);
`ifdef DHT_FMT_RANGE_CHECK_EN
  assign range_err = r_range_err;
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_dht_bcd_formatter.sv
// Scoreboard bench for dht_bcd_formatter: stimulus pushes expectations,
// a monitor pops and compares whenever a result is presented.
module tb_dht_bcd_formatter;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] t;
    logic        n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] dht_data = 32'h0;
  logic        out_valid;
  logic [15:0] hum_bcd;
  logic [15:0] temp_bcd;
  logic        temp_neg;
  logic        range_err;
  logic        busy;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int err_cnt = 0;

  dht_bcd_formatter dut (
    .clk       (clk),
    .rst       (rst),
    .dht_data  (dht_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .hum_bcd   (hum_bcd),
    .temp_bcd  (temp_bcd),
    .temp_neg  (temp_neg),
    .range_err (range_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: compare on the first presented cycle, then check stability.
  initial begin
    logic seen;
    exp_t e;
    exp_t held;
    seen = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #1;
      if (range_err === 1'b1) err_cnt++;
      if (!rst) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result hum=%h temp=%h", hum_bcd, temp_bcd);
          end else begin
            e = q.pop_front();
            chk("hum_bcd", 32'(hum_bcd), 32'(e.h));
            chk("temp_bcd", 32'(temp_bcd), 32'(e.t));
            chk("temp_neg", 32'(temp_neg), 32'(e.n));
          end
          held = '{h: hum_bcd, t: temp_bcd, n: temp_neg};
        end else begin
          chk("stable", {hum_bcd, temp_bcd[14:0], temp_neg},
              {held.h, held.t[14:0], held.n});
        end
      end else begin
        seen = 1'b0;
      end
    end
  end

  task automatic wait_valid(input int lat);
    int n;
    n = 0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        n = i;
        break;
      end
    end
    chk("latency", 32'(n), 32'(lat));
  endtask

  task automatic wait_idle();
    int ok;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!out_valid && !busy) begin
        ok = 1;
        break;
      end
    end
    chk("return_idle", 32'(ok), 32'd1);
  endtask

  task automatic run(input logic [31:0] d, input logic [15:0] h,
                     input logic [15:0] t, input logic n);
    @(negedge clk);
    dht_data = d;
    q.push_back('{h: h, t: t, n: n});
    wait_valid(34);
    wait_idle();
  endtask

`ifdef DHT_FMT_RANGE_CHECK_EN
  task automatic reject(input logic [31:0] d);
    int e0;
    int v;
    e0 = err_cnt;
    v = 0;
    @(negedge clk);
    dht_data = d;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) v++;
    end
    chk("range_err_pulses", 32'(err_cnt - e0), 32'd1);
    chk("rejected_no_valid", 32'(v), 32'd0);
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_bcd", {hum_bcd, temp_bcd}, 32'h0);
    chk("rst_flags", {29'd0, temp_neg, range_err, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("zero_not_new", 32'(busy), 32'd0);

    run(32'h028C_010F, 16'h0652, 16'h0271, 1'b0);
    run(32'h0190_8065, 16'h0400, 16'h0101, 1'b1);
    run(32'h0190_8000, 16'h0400, 16'h0000, 1'b0);
`ifdef DHT_FMT_RANGE_CHECK_EN
    reject(32'h0500_0000);
    reject(32'h0000_0400);
`else
    run(32'h0500_0000, 16'h1000, 16'h0000, 1'b0);
    run(32'h0000_0400, 16'h0000, 16'h0800, 1'b0);
`endif

    // Backpressure with input changes while presenting
    @(negedge clk);
    out_ready = 1'b0;
    dht_data = 32'h0123_0156;
    q.push_back('{h: 16'h0291, t: 16'h0342, n: 1'b0});
    wait_valid(34);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 5) dht_data = 32'h0011_0022;
      if (i == 10) dht_data = 32'h0258_8123;
    end
    chk("held_valid", 32'(out_valid), 32'd1);
    q.push_back('{h: 16'h0600, t: 16'h0291, n: 1'b1});
    @(negedge clk);
    out_ready = 1'b1;
    wait_valid(35);
    wait_idle();
    repeat (40) @(posedge clk);
    chk("dropped_intermediate", 32'(q.size()), 32'd0);

    // Reset during humidity conversion
    @(negedge clk);
    dht_data = 32'h0300_0050;
    repeat (11) @(posedge clk);
    #2;
    chk("busy_mid_conv", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_bcd", {hum_bcd, temp_bcd}, 32'h0);
    chk("abort_flags", {29'd0, temp_neg, range_err, busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    q.push_back('{h: 16'h0768, t: 16'h0080, n: 1'b0});
    wait_valid(34);
    wait_idle();
    chk("queue_empty", 32'(q.size()), 32'd0);
`ifndef DHT_FMT_RANGE_CHECK_EN
    chk("range_err_tied", 32'(err_cnt), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
